// File: rtl/axis_pkg.sv
// Shared defaults for the AXI-Stream register FIFO slice.
package axis_pkg;
  localparam int unsigned AXIS_DATA_W = 8;
  localparam int unsigned AXIS_DEPTH  = 4;
  localparam int unsigned PKT_CNT_W   = 16;
endpackage

// File: rtl/axis_ready_throttle.sv
// Periodic accept window: open for THR_ON cycles, closed for THR_OFF, repeating from reset release.
module axis_ready_throttle #(
  parameter int unsigned THR_EN  = 0,
  parameter int unsigned THR_ON  = 3,
  parameter int unsigned THR_OFF = 2
) (
  input  logic clk,
  input  logic rst,
  output logic thr_open
);

  localparam int unsigned PERIOD = THR_ON + THR_OFF;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  generate
    if (THR_EN == 0) begin : g_always_open
      logic unused_ok;
      assign unused_ok = clk ^ rst;
      assign thr_open  = 1'b1;
    end else begin : g_periodic
      logic [CNT_W-1:0] phase_q;
      logic [CNT_W-1:0] phase_d;

      always_comb begin
        phase_d = phase_q;
        if (rst) begin
          phase_d = '0;
        end else if (phase_q == CNT_W'(PERIOD - 1)) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        phase_q <= phase_d;
      end

      // Compare one bit wider so THR_ON equal to a power of two cannot alias to zero.
      assign thr_open = ({1'b0, phase_q} < (CNT_W + 1)'(THR_ON));
    end
  endgenerate

endmodule

// File: rtl/axis_reg_fifo.sv
// First-word-fall-through AXI-Stream FIFO with registered s_ready, packet counter and optional throttle.
module axis_reg_fifo
  import axis_pkg::*;
#(
  parameter int unsigned DATA_W  = AXIS_DATA_W,
  parameter int unsigned DEPTH   = AXIS_DEPTH,
  parameter int unsigned THR_EN  = 0,
  parameter int unsigned THR_ON  = 3,
  parameter int unsigned THR_OFF = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_last,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic [PKT_CNT_W-1:0]     pkt_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic               thr_open;
  logic               push;
  logic               pop;
  entry_t             rd_entry;

  axis_ready_throttle #(
    .THR_EN (THR_EN),
    .THR_ON (THR_ON),
    .THR_OFF(THR_OFF)
  ) u_throttle (
    .clk     (clk),
    .rst     (rst),
    .thr_open(thr_open)
  );

  // count never exceeds DEPTH, so its MSB alone marks full; m_ready never reaches s_ready.
  assign s_ready  = !rst && !count_q[PTR_W] && thr_open;
  assign m_valid  = !rst && (count_q != '0);
  assign push     = s_valid && s_ready;
  assign pop      = m_valid && m_ready;
  assign rd_entry = mem_q[rd_ptr_q];
  assign m_data   = rd_entry.data;
  assign m_last   = rd_entry.last;
  assign count    = rst ? '0 : count_q;
  assign pkt_cnt  = rst ? '0 : pkt_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pkt_cnt_d = pkt_cnt_q;
    if (rst) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pkt_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_entry.last) begin
          pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q  <= wr_ptr_d;
    rd_ptr_q  <= rd_ptr_d;
    count_q   <= count_d;
    pkt_cnt_q <= pkt_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{last: s_last, data: s_data};
    end
  end

endmodule

// File: tb/tb_axis_reg_fifo.sv
// Scoreboard bench: an unthrottled and a throttled FIFO share one stimulus stream, each against its own queue model.
module tb_axis_reg_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b0;

  logic       s_ready_a, m_valid_a, m_last_a;
  logic [7:0] m_data_a;
  logic [2:0] count_a;
  logic [15:0] pkt_a;
  logic       s_ready_b, m_valid_b, m_last_b;
  logic [7:0] m_data_b;
  logic [2:0] count_b;
  logic [15:0] pkt_b;

  int checks = 0;
  int failures = 0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int mcnt[2];
  int exp_pkt[2];
  int phase = 0;

  always #5 clk = ~clk;

  axis_reg_fifo dut_a (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a), .s_last(s_last),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
    .count(count_a), .pkt_cnt(pkt_a)
  );

  axis_reg_fifo #(.DATA_W(8), .DEPTH(4), .THR_EN(1), .THR_ON(3), .THR_OFF(2)) dut_b (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b), .s_last(s_last),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
    .count(count_b), .pkt_cnt(pkt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, want, $time);
    end
  endtask

  // Reference model: occupancy and accept window from first principles; accepted beats go to the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic sr, mv;
      logic [2:0] cnt;
      bit open, esr, emv;
      if (d == 0) begin sr = s_ready_a; mv = m_valid_a; cnt = count_a; end
      else        begin sr = s_ready_b; mv = m_valid_b; cnt = count_b; end
      open = (d == 0) || (phase < 3);
      if (rst) begin
        chk($sformatf("rst_s_ready[%0d]", d), 32'(sr), 0);
        chk($sformatf("rst_m_valid[%0d]", d), 32'(mv), 0);
        chk($sformatf("rst_count[%0d]", d), 32'(cnt), 0);
        mcnt[d] = 0;
        if (d == 0) q_a.delete(); else q_b.delete();
      end else begin
        esr = (mcnt[d] < DEPTH) && open;
        emv = (mcnt[d] != 0);
        chk($sformatf("s_ready[%0d]", d), 32'(sr), 32'(esr));
        chk($sformatf("m_valid[%0d]", d), 32'(mv), 32'(emv));
        chk($sformatf("count[%0d]", d), 32'(cnt), 32'(mcnt[d]));
        if (s_valid && esr) begin
          if (d == 0) q_a.push_back({s_last, s_data}); else q_b.push_back({s_last, s_data});
          mcnt[d]++;
        end
        if (m_ready && emv) mcnt[d]--;
      end
    end
    phase = rst ? 0 : (phase + 1) % 5;
  end

  // Monitor: compares presented beats with the scoreboard head and tracks completed packets.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic mv, ml;
      logic [7:0] md;
      logic [15:0] pc;
      logic [8:0] head;
      int qsize;
      if (d == 0) begin mv = m_valid_a; ml = m_last_a; md = m_data_a; pc = pkt_a; qsize = q_a.size(); end
      else        begin mv = m_valid_b; ml = m_last_b; md = m_data_b; pc = pkt_b; qsize = q_b.size(); end
      if (rst) begin
        chk($sformatf("rst_pkt_cnt[%0d]", d), 32'(pc), 0);
        exp_pkt[d] = 0;
      end else begin
        chk($sformatf("pkt_cnt[%0d]", d), 32'(pc), 32'(exp_pkt[d]));
        if (mv) begin
          if (qsize == 0) begin
            chk($sformatf("beat_without_push[%0d]", d), 32'(mv), 0);
          end else begin
            head = (d == 0) ? q_a[0] : q_b[0];
            chk($sformatf("m_beat[%0d]", d), {23'b0, ml, md}, {23'b0, head});
            if (m_ready) begin
              if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
              if (head[8]) exp_pkt[d] = (exp_pkt[d] + 1) % 65536;
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic mr);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] pv [3];
    pv[0] = 8'h11; pv[1] = 8'h22; pv[2] = 8'h33;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Passthrough: each beat visible one cycle after its push edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pv[i], (i == 2), 1'b1);
      chk("pass_m_valid", 32'(m_valid_a), 1);
      chk("pass_m_data", 32'(m_data_a), 32'(pv[i]));
    end
    idle(4);
    chk("pass_pkt_cnt", 32'(pkt_a), 1);

    // Fill to full with the sink stalled; the fifth beat is refused.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("full_count", 32'(count_a), 4);
    chk("full_s_ready", 32'(s_ready_a), 0);
    chk("full_head", 32'(m_data_a), 32'hA0);
    drive(1'b1, 8'hA5, 1'b0, 1'b1);
    chk("full_pop_count", 32'(count_a), 3);
    chk("full_pop_s_ready", 32'(s_ready_a), 1);
    idle(8);

    // Pointer wrap at constant occupancy.
    drive(1'b1, 8'hB0, 1'b0, 1'b0);
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'hC0 + 8'(i), (i == 9), 1'b1);
    chk("wrap_count", 32'(count_a), 2);
    idle(8);

    // Continuous offer from reset release exercises the throttle window.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), (i % 4 == 3), 1'b1);
    idle(8);

    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    idle(8);

    // Reset with three beats held discards them.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_a), 3);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    chk("post_rst_m_valid", 32'(m_valid_a), 0);
    chk("post_rst_count", 32'(count_a), 0);
    chk("post_rst_pkt_cnt", 32'(pkt_a), 0);
    idle(3);
    chk("post_rst_idle_m_valid", 32'(m_valid_a), 0);

    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
